// File: rtl/exec_hazard_ctrl.sv
// Execution-stage hazard controller: operand forwarding, load-use stall, taken-branch flush, multi-cycle MUL hold.
// Optional macro HAZARD_PERF_CNT_EN adds the perf_mul_stalls / perf_load_stalls / perf_flushes counters.
module exec_hazard_ctrl #(
    parameter int unsigned MUL_LATENCY = 32'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs1_ID,
    input  logic [4:0] rs2_ID,
    input  logic       uses_rs1_ID,
    input  logic       uses_rs2_ID,
    input  logic [4:0] rd_EX,
    input  logic       regwrite_EX,
    input  logic       memread_EX,
    input  logic       is_mul_EX,
    input  logic       branch_taken_EX,
    input  logic [4:0] rd_MEM,
    input  logic       regwrite_MEM,
    output logic [1:0] forward_select_A,
    output logic [1:0] forward_select_B,
    output logic       stall_front,
    output logic       bubble_EX,
    output logic       flush_ID,
    output logic       stall_pipe,
    output logic       wb_enable
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_mul_stalls,
    output logic [31:0] perf_load_stalls,
    output logic [31:0] perf_flushes
`endif
);

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_t;

    localparam bit         MUL_STALLS = (MUL_LATENCY > 32'd1);
    localparam logic [3:0] CNT_INIT   = 4'(MUL_LATENCY - 32'd2);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_stall_pipe;
    logic       w_ex_rd_valid;
    logic       w_mem_rd_valid;
    logic       w_load_use;
    logic       w_stall_front;
    logic       w_bubble_ex;
    logic       w_flush_id;
    logic [1:0] r_fwd_a;
    logic [1:0] r_fwd_b;
    logic [1:0] w_fwd_a_nxt;
    logic [1:0] w_fwd_b_nxt;

    // Newest producer wins: EX result (via MEM path) before the older MEM result (via WB path).
    function automatic logic [1:0] fwd_code(
        input logic [4:0] rs,
        input logic       rs_used,
        input logic [4:0] rd_ex,
        input logic       ex_valid,
        input logic [4:0] rd_mem,
        input logic       mem_valid
    );
        logic [1:0] code;
        if (rs_used && ex_valid && (rs == rd_ex)) begin
            code = FWD_MEM;
        end else if (rs_used && mem_valid && (rs == rd_mem)) begin
            code = FWD_WB;
        end else begin
            code = FWD_RF;
        end
        return code;
    endfunction

    assign w_ex_rd_valid  = regwrite_EX  & (rd_EX  != 5'd0);
    assign w_mem_rd_valid = regwrite_MEM & (rd_MEM != 5'd0);
    assign w_load_use     = memread_EX & w_ex_rd_valid &
                            ((uses_rs1_ID & (rs1_ID == rd_EX)) |
                             (uses_rs2_ID & (rs2_ID == rd_EX)));

    // MUL sequencing: next state, countdown and the whole-pipeline stall.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_stall_pipe = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (is_mul_EX && MUL_STALLS) begin
                    w_stall_pipe = 1'b1;
                    w_state_nxt  = ST_MUL_BUSY;
                    w_cnt_nxt    = CNT_INIT;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_MUL_BUSY: begin
                if (r_cnt != 4'd0) begin
                    w_stall_pipe = 1'b1;
                    w_cnt_nxt    = r_cnt - 4'd1;
                end else begin
                    // Result is ready; the MUL leaves EX at this edge.
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Front-end control with priority: pipeline stall, then branch flush, then load-use.
    always_comb begin
        w_stall_front = 1'b0;
        w_bubble_ex   = 1'b0;
        w_flush_id    = 1'b0;
        if (w_stall_pipe) begin
            w_stall_front = 1'b0;
        end else if (branch_taken_EX) begin
            w_flush_id  = 1'b1;
            w_bubble_ex = 1'b1;
        end else if (w_load_use) begin
            w_stall_front = 1'b1;
            w_bubble_ex   = 1'b1;
        end else begin
            w_bubble_ex = 1'b0;
        end
    end

    // Forward codes for the instruction entering EX at the next edge.
    always_comb begin
        w_fwd_a_nxt = r_fwd_a;
        w_fwd_b_nxt = r_fwd_b;
        if (w_stall_pipe) begin
            w_fwd_a_nxt = r_fwd_a;
            w_fwd_b_nxt = r_fwd_b;
        end else if (w_bubble_ex) begin
            w_fwd_a_nxt = FWD_RF;
            w_fwd_b_nxt = FWD_RF;
        end else begin
            w_fwd_a_nxt = fwd_code(rs1_ID, uses_rs1_ID, rd_EX, w_ex_rd_valid, rd_MEM, w_mem_rd_valid);
            w_fwd_b_nxt = fwd_code(rs2_ID, uses_rs2_ID, rd_EX, w_ex_rd_valid, rd_MEM, w_mem_rd_valid);
        end
    end

    // FSM state and countdown registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Forward-select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else begin
            r_fwd_a <= w_fwd_a_nxt;
            r_fwd_b <= w_fwd_b_nxt;
        end
    end

    assign forward_select_A = r_fwd_a;
    assign forward_select_B = r_fwd_b;
    assign stall_front      = w_stall_front;
    assign bubble_EX        = w_bubble_ex;
    assign flush_ID         = w_flush_id;
    assign stall_pipe       = w_stall_pipe;
    assign wb_enable        = ~w_stall_pipe;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_mul;
    logic [31:0] r_perf_load;
    logic [31:0] r_perf_flush;

    // Event counters; they keep counting while the pipeline is frozen and wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_mul   <= 32'd0;
            r_perf_load  <= 32'd0;
            r_perf_flush <= 32'd0;
        end else begin
            r_perf_mul   <= r_perf_mul   + {31'd0, w_stall_pipe};
            r_perf_load  <= r_perf_load  + {31'd0, w_stall_front};
            r_perf_flush <= r_perf_flush + {31'd0, w_flush_id};
        end
    end

    assign perf_mul_stalls  = r_perf_mul;
    assign perf_load_stalls = r_perf_load;
    assign perf_flushes     = r_perf_flush;
`endif

endmodule

// File: doc/exec_hazard_ctrl.md
Name: exec_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RV32IM pipeline's execution stage.
- Generates the registered forward_select_A/B codes the execution stage consumes.
- Detects load-use hazards (stall front end, inject EX bubble) and taken-branch flushes.
- Sequences a multi-cycle MUL: holds the whole pipeline while the multiplier result settles.

Parameters:
- MUL_LATENCY, 3: cycles a MUL occupies EX; legal range 1..15; 1 means no stall.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rs1_ID, rs2_ID  input  5  source registers of the instruction in ID.
- uses_rs1_ID, uses_rs2_ID  input  1  ID instruction actually reads rs1/rs2.
- rd_EX  input  5  destination register of the EX instruction.
- regwrite_EX  input  1  EX instruction writes the register file.
- memread_EX  input  1  EX instruction is a load.
- is_mul_EX  input  1  EX instruction is MUL (ALU_Control == MUL).
- branch_taken_EX  input  1  EX resolved a taken branch or jump.
- rd_MEM  input  5  destination register of the MEM instruction.
- regwrite_MEM  input  1  MEM instruction writes the register file.
- forward_select_A, forward_select_B  output  2  registered: 00 = regfile, 01 = WB, 10 = MEM.
- stall_front  output  1  hold PC and the IF/ID register.
- bubble_EX  output  1  load ID/EX with a NOP.
- flush_ID  output  1  load IF/ID with a NOP.
- stall_pipe  output  1  freeze the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- wb_enable  output  1  regfile write gate; equals ~stall_pipe.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, cnt = 0, forward_select_A/B = 00, perf counters = 0.
  - Combinational outputs then follow their equations with state = IDLE.
- MUL FSM, states IDLE and MUL_BUSY, 4-bit cnt:
  - IDLE with is_mul_EX = 1 and MUL_LATENCY > 1: stall_pipe = 1; next state MUL_BUSY; cnt <= MUL_LATENCY-2.
  - MUL_BUSY with cnt != 0: stall_pipe = 1; cnt decrements.
  - MUL_BUSY with cnt == 0: stall_pipe = 0 (MUL leaves EX at this edge); next state IDLE.
  - Net effect: the MUL spends exactly MUL_LATENCY cycles in EX, with MUL_LATENCY-1 stalled cycles.
  - A back-to-back MUL restarts from IDLE on the following cycle.
- Load-use hazard (evaluated only when stall_pipe = 0):
  - Condition: memread_EX & regwrite_EX & rd_EX != 0 & ((uses_rs1_ID & rs1_ID == rd_EX) | (uses_rs2_ID & rs2_ID == rd_EX)).
  - Response: stall_front = 1 and bubble_EX = 1 for exactly one cycle; the hazard clears once the load moves to MEM.
- Taken branch (evaluated only when stall_pipe = 0):
  - branch_taken_EX = 1 gives flush_ID = 1 and bubble_EX = 1.
  - Branch wins over a simultaneous load-use hazard: stall_front = 0.
- Priority: stall_pipe > branch flush > load-use. While stall_pipe = 1, stall_front, bubble_EX and flush_ID are all 0.
- Forwarding registers, per operand X in {A, B}:
  - stall_pipe = 1: hold.
  - Else if bubble_EX: load 00.
  - Else load from the ID instruction:
    - 10 when regwrite_EX & rd_EX != 0 & rsX_ID == rd_EX & usesX.
    - Else 01 when regwrite_MEM & rd_MEM != 0 & rsX_ID == rd_MEM & usesX.
    - Else 00.
  - The EX match takes priority over the MEM match (newest producer wins). x0 is never forwarded.
- All control outputs except forward_select are combinational from state and inputs; forward_select is valid from the cycle the instruction enters EX.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds 32-bit outputs perf_mul_stalls, perf_load_stalls and perf_flushes, incrementing on cycles where stall_pipe, the load-use stall_front, and flush_ID are 1 respectively.
  - Counters wrap at 2^32, reset to 0 asynchronously, and are not affected by stall_pipe.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n low mid-MUL_BUSY (cnt = 1) -> state IDLE, forward selects 00 and stall_pipe 0 immediately, with no clock edge needed.
- Forwarding: add x5 in EX and add x6 in MEM, ID reads rs1 = x5, rs2 = x6 -> after the edge, forward_select_A = 10, forward_select_B = 01; ID reads x0 with rd_EX = 0 -> 00.
- Load-use: lw x7 in EX, ID add uses rs2 = x7 -> one cycle of stall_front = 1 and bubble_EX = 1; next cycle the add enters EX with forward_select_B = 01 (load now in WB).
- MUL, MUL_LATENCY = 3: is_mul_EX asserted -> stall_pipe = 1, 1, 0 over three cycles and wb_enable = 0, 0, 1; a second MUL immediately after repeats the pattern.
- Branch vs load-use: branch_taken_EX = 1 together with a load-use match -> flush_ID = 1, bubble_EX = 1, stall_front = 0.
- MUL_LATENCY = 1: is_mul_EX = 1 -> stall_pipe stays 0 and the FSM stays in IDLE.
